// File: rtl/qmult_rr_sched_if.sv
// -----------------------------------------------------------------------------
// qmult_rr_sched_if
// Bundle of signals between the round-robin multiplier scheduler, its
// requesters, the shared fixed-point multiplier and the response consumer.
//
//   req_valid  [NREQ]      per-requester request valid
//   req_a      [NREQ*N]    packed multiplicands, requester i at [i*N +: N]
//   req_b      [NREQ*N]    packed multipliers, same packing
//   req_ready  [NREQ]      one-hot grant/accept strobe
//   mul_a/mul_b [N]        registered operands to the shared multiplier
//   mul_result [N]         combinational product from the multiplier
//   mul_ovr                combinational overflow from the multiplier
//   rsp_valid/rsp_ready    response handshake
//   rsp_id     [IDW]       requester index of the response
//   rsp_result [N]         product, signed N,Q
//   rsp_ovr                overflow flag of the product
//   busy                   scheduler not idle
//
// slave  : the scheduler's view
// master : the environment's view (requesters, multiplier, consumer)
// -----------------------------------------------------------------------------
interface qmult_rr_sched_if #(
    parameter int N    = 32,
    parameter int NREQ = 4
) ();
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic [N-1:0]      mul_a;
    logic [N-1:0]      mul_b;
    logic [N-1:0]      mul_result;
    logic              mul_ovr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [N-1:0]      rsp_result;
    logic              rsp_ovr;
    logic              busy;

    modport slave (
        input  req_valid, req_a, req_b, mul_result, mul_ovr, rsp_ready,
        output req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_result,
               rsp_ovr, busy
    );

    modport master (
        output req_valid, req_a, req_b, mul_result, mul_ovr, rsp_ready,
        input  req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_result,
               rsp_ovr, busy
    );
endinterface

// File: rtl/qmult_rr_sched.sv
// -----------------------------------------------------------------------------
// qmult_rr_sched
// Round-robin scheduler sharing one external signed fixed-point multiplier
// (format N,Q) between NREQ requesters. One transaction takes three states:
// IDLE (grant + operand load), MUL (multiplier settles, product captured),
// RSP (response held until accepted).
//
// Ports:
//   clk    rising-edge system clock
//   rst_n  asynchronous active-low reset
//   bus    qmult_rr_sched_if.slave (request, multiplier and response signals)
//
// Optional feature: define QMULT_SCHED_SATURATE_EN to saturate rsp_result to
// +/-(2^(N-1)-1) whenever the multiplier reports overflow.
// -----------------------------------------------------------------------------
module qmult_rr_sched #(
    parameter int N    = 32,
    parameter int Q    = 15,
    parameter int NREQ = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    qmult_rr_sched_if.slave   bus
);
    localparam int IDW = $clog2(NREQ);

    // Reject configurations the datapath is not built for.
    if ((Q < 0) || (Q >= N) || (NREQ < 2) || (NREQ > 16)) begin : g_param_check
        $error("qmult_rr_sched: illegal parameters N=%0d Q=%0d NREQ=%0d", N, Q, NREQ);
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [IDW-1:0]  ptr_r;
    logic [IDW-1:0]  id_r;
    logic [N-1:0]    mul_a_r;
    logic [N-1:0]    mul_b_r;
    logic            rsp_valid_r;
    logic [IDW-1:0]  rsp_id_r;
    logic [N-1:0]    rsp_result_r;
    logic            rsp_ovr_r;

    logic            grant_found_s;
    logic [IDW-1:0]  grant_id_s;
    logic [NREQ-1:0] req_ready_s;
    logic            load_s;
    logic            cap_s;
    logic            done_s;
    logic            busy_s;

`ifdef QMULT_SCHED_SATURATE_EN
    // Largest magnitude representable symmetrically, sign chosen by operand signs.
    function automatic logic [N-1:0] sat_result(input logic [N-1:0] prod,
                                                input logic          ovr,
                                                input logic          neg);
        logic [N-1:0] res;
        res = prod;
        if (ovr) begin
            if (neg) begin
                res = {1'b1, {(N-2){1'b0}}, 1'b1};
            end else begin
                res = {1'b0, {(N-1){1'b1}}};
            end
        end else begin
            res = prod;
        end
        return res;
    endfunction
`endif

    // Round-robin search starting just after the last granted requester.
    always_comb begin : arbiter
        int unsigned cand;
        cand          = 0;
        grant_found_s = 1'b0;
        grant_id_s    = {IDW{1'b0}};
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(ptr_r) + k) % NREQ;
            if (!grant_found_s && bus.req_valid[cand]) begin
                grant_found_s = 1'b1;
                grant_id_s    = cand[IDW-1:0];
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_found_s) begin
                    state_nxt_s = ST_MUL;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_MUL:  state_nxt_s = ST_RSP;
            ST_RSP: begin
                // rsp_valid is always high in RSP, so rsp_ready alone completes it.
                if (bus.rsp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RSP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State-dependent strobes; req_ready is forced low while reset is held.
    always_comb begin
        req_ready_s = {NREQ{1'b0}};
        load_s      = 1'b0;
        cap_s       = 1'b0;
        done_s      = 1'b0;
        busy_s      = 1'b1;
        case (state_r)
            ST_IDLE: begin
                busy_s = 1'b0;
                load_s = grant_found_s;
                if (grant_found_s && rst_n) begin
                    req_ready_s = {{(NREQ-1){1'b0}}, 1'b1} << grant_id_s;
                end else begin
                    req_ready_s = {NREQ{1'b0}};
                end
            end
            ST_MUL:  cap_s  = 1'b1;
            ST_RSP:  done_s = bus.rsp_ready;
            default: busy_s = 1'b1;
        endcase
    end

    // Operand load, product capture and response hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r        <= IDW'(NREQ - 1);
            id_r         <= {IDW{1'b0}};
            mul_a_r      <= {N{1'b0}};
            mul_b_r      <= {N{1'b0}};
            rsp_valid_r  <= 1'b0;
            rsp_id_r     <= {IDW{1'b0}};
            rsp_result_r <= {N{1'b0}};
            rsp_ovr_r    <= 1'b0;
        end else begin
            if (load_s) begin
                mul_a_r <= bus.req_a[int'(grant_id_s)*N +: N];
                mul_b_r <= bus.req_b[int'(grant_id_s)*N +: N];
                id_r    <= grant_id_s;
                ptr_r   <= grant_id_s;
            end
            if (cap_s) begin
`ifdef QMULT_SCHED_SATURATE_EN
                rsp_result_r <= sat_result(bus.mul_result, bus.mul_ovr,
                                           mul_a_r[N-1] ^ mul_b_r[N-1]);
`else
                rsp_result_r <= bus.mul_result;
`endif
                rsp_ovr_r   <= bus.mul_ovr;
                rsp_id_r    <= id_r;
                rsp_valid_r <= 1'b1;
            end
            if (done_s) begin
                rsp_valid_r <= 1'b0;
            end
        end
    end

    assign bus.req_ready  = req_ready_s;
    assign bus.mul_a      = mul_a_r;
    assign bus.mul_b      = mul_b_r;
    assign bus.rsp_valid  = rsp_valid_r;
    assign bus.rsp_id     = rsp_id_r;
    assign bus.rsp_result = rsp_result_r;
    assign bus.rsp_ovr    = rsp_ovr_r;
    assign bus.busy       = busy_s;

endmodule
